// File: rtl/host_comm_pkg.sv
// host_comm_pkg: shared types and constants for the host-side UART command master.
//   cmd_state_e : command FSM states (idle / sending high byte / sending low byte)
//   rx_state_e  : receive deserialiser states
//   BITS_PER_FRAME, DATA_BITS : 8N1 frame geometry
//   POS_ACK / NEG_ACK         : response bytes returned by the device under test
package host_comm_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_HIGH = 2'd1,
    CMD_LOW  = 2'd2
  } cmd_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned BITS_PER_FRAME = 10;
  localparam int unsigned DATA_BITS      = 8;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'hEE;

endpackage

// File: rtl/host_comm_uart.sv
// host_comm_uart: 8N1 UART with independent TX shifter and RX deserialiser.
// Ports:
//   clk, rst_n      : clock, synchronous active-high reset
//   RX              : asynchronous serial input (idles high)
//   TX              : registered serial output (idles high)
//   trmt, tx_data   : start sending tx_data (ignored while a frame is in flight)
//   tx_done         : one-cycle pulse after the stop bit has been sent
//   rx_rdy, rx_data : one-cycle pulse with the received byte at the stop-bit sample
module host_comm_uart
  import host_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 108
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2 - 1);

  // TX: shift_q[0] drives the line directly, so an all-ones shifter means idle.
  logic [9:0]       tx_shift_q, tx_shift_d;
  logic             tx_busy_q, tx_busy_d;
  logic [CNT_W-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic             tx_done_q, tx_done_d;

  // RX
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_rdy_q, rx_rdy_d;

  assign TX      = tx_shift_q[0];
  assign tx_done = tx_done_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;

  // TX next-state: start, 8 data bits LSB first, stop; ones shifted in behind.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_busy_d  = tx_busy_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_done_d  = 1'b0;
    if (trmt && !tx_busy_q) begin
      tx_shift_d = {1'b1, tx_data, 1'b0};
      tx_busy_d  = 1'b1;
      tx_baud_d  = '0;
      tx_bit_d   = '0;
    end else if (tx_busy_q) begin
      if (tx_baud_q == FULL_CNT) begin
        tx_baud_d  = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        if (tx_bit_q == 4'(BITS_PER_FRAME - 1)) begin
          tx_busy_d = 1'b0;
          tx_done_d = 1'b1;
          tx_bit_d  = '0;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end else begin
        tx_baud_d = tx_baud_q + CNT_W'(1);
      end
    end
  end

  // RX next-state: sample mid-bit; a start bit that is high again at mid-bit is a glitch.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_rdy_d   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_baud_d  = '0;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_CNT) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_d = rx_baud_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_baud_q == FULL_CNT) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 4'(DATA_BITS - 1)) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // The stop-bit level is not qualified: the byte is delivered either way.
        if (rx_baud_q == FULL_CNT) begin
          rx_baud_d  = '0;
          rx_data_d  = rx_shift_q;
          rx_rdy_d   = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_baud_d = rx_baud_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // State registers and RX synchroniser.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_shift_q <= '1;
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_done_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_busy_q  <= tx_busy_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_done_q  <= tx_done_d;
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

endmodule

// File: rtl/host_comm_master.sv
// host_comm_master: PC-host stand-in that sends a 16-bit command as two UART bytes
// (high byte first) and captures the single-byte response.
// Ports:
//   clk, rst_n        : clock, synchronous active-high reset
//   RX / TX           : serial in (from analyzer TX) / serial out (to analyzer RX)
//   cmd, snd_cmd      : command word and its one-cycle send strobe (accepted in idle only)
//   cmd_cmplt         : set once both bytes are sent, cleared by the next accepted snd_cmd
//   rdy, resp         : response-available flag and last received byte
//   clr_resp_rdy      : one-cycle strobe clearing rdy (a same-cycle byte arrival wins)
// Build option: CMD_MASTER_RDY_AUTOCLR_EN makes an accepted snd_cmd also clear rdy.
module host_comm_master
  import host_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 108
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_cmplt,
  output logic        rdy,
  output logic [7:0]  resp,
  input  logic        clr_resp_rdy
);

  cmd_state_e state_q, state_d;
  logic [7:0] cmd_lo_q, cmd_lo_d;
  logic       cmplt_q, cmplt_d;
  logic       rdy_q, rdy_d;
  logic [7:0] resp_q, resp_d;
  logic       trmt_c;
  logic [7:0] tx_data_c;
  logic       clr_c;
  logic       tx_done;
  logic       rx_rdy;
  logic [7:0] rx_data;

  assign cmd_cmplt = cmplt_q;
  assign rdy       = rdy_q;
  assign resp      = resp_q;

  host_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .trmt    (trmt_c),
    .tx_data (tx_data_c),
    .tx_done (tx_done),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data)
  );

  // Command FSM: the high byte goes straight from cmd, the low byte from the latch.
  always_comb begin
    state_d   = state_q;
    cmd_lo_d  = cmd_lo_q;
    cmplt_d   = cmplt_q;
    trmt_c    = 1'b0;
    tx_data_c = cmd[15:8];
    unique case (state_q)
      CMD_IDLE: begin
        if (snd_cmd) begin
          cmd_lo_d = cmd[7:0];
          cmplt_d  = 1'b0;
          trmt_c   = 1'b1;
          state_d  = CMD_HIGH;
        end
      end
      CMD_HIGH: begin
        if (tx_done) begin
          trmt_c    = 1'b1;
          tx_data_c = cmd_lo_q;
          state_d   = CMD_LOW;
        end
      end
      CMD_LOW: begin
        if (tx_done) begin
          cmplt_d = 1'b1;
          state_d = CMD_IDLE;
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  // Response flag: a completing byte has priority over any clear.
  always_comb begin
`ifdef CMD_MASTER_RDY_AUTOCLR_EN
    clr_c = clr_resp_rdy || ((state_q == CMD_IDLE) && snd_cmd);
`else
    clr_c = clr_resp_rdy;
`endif
    rdy_d  = rdy_q;
    resp_d = resp_q;
    if (rx_rdy) begin
      rdy_d  = 1'b1;
      resp_d = rx_data;
    end else if (clr_c) begin
      rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= CMD_IDLE;
      cmd_lo_q <= '0;
      cmplt_q  <= 1'b0;
      rdy_q    <= 1'b0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmd_lo_q <= cmd_lo_d;
      cmplt_q  <= cmplt_d;
      rdy_q    <= rdy_d;
      resp_q   <= resp_d;
    end
  end

endmodule

// File: tb/tb_host_comm_master.sv
// tb_host_comm_master: self-checking bench for host_comm_master (table vectors,
// directed multi-cycle sequences and randomized full-duplex traffic).
module tb_host_comm_master;
  import host_comm_pkg::*;

  localparam int BAUD = 108;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        clr_resp_rdy;
  logic        TX;
  logic        cmd_cmplt;
  logic        rdy;
  logic [7:0]  resp;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  host_comm_master #(.BAUD_DIV(BAUD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RX           (RX),
    .TX           (TX),
    .cmd          (cmd),
    .snd_cmd      (snd_cmd),
    .cmd_cmplt    (cmd_cmplt),
    .rdy          (rdy),
    .resp         (resp),
    .clr_resp_rdy (clr_resp_rdy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Line-level decoder of TX: frames captured by mid-bit sampling.
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         st;
  } frame_t;
  frame_t txq[$];

  initial begin : tx_mon
    frame_t f;
    forever begin
      @(negedge clk);
      if (TX === 1'b0) begin
        f.st = cyc;
        repeat (BAUD / 2 - 1) @(negedge clk);
        if (TX === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            f.data[i] = TX;
          end
          repeat (BAUD) @(negedge clk);
          f.stop = TX;
          txq.push_back(f);
        end
      end
    end
  end

  // Drive one 8N1 frame on RX; call at a negedge.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = stop;
    repeat (BAUD) @(negedge clk);
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic issue_cmd(input logic [15:0] c);
    cmd     = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  // Clocks from the snd_cmd edge to cmd_cmplt rising; call right after issue_cmd.
  task automatic wait_cmplt(output int lat);
    int cnt = 1;
    while (cmd_cmplt !== 1'b1 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    lat = cnt - 1;
  endtask

  task automatic pulse_clr(input string tag, input logic exp_rdy);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    chk({tag, " rdy_after_clr"}, 32'(rdy), 32'(exp_rdy));
  endtask

  // Full command: two frames with the expected bytes, back to back, then cmd_cmplt.
  task automatic run_cmd(input string tag, input logic [15:0] c,
                         input logic [7:0] eh, input logic [7:0] el);
    int lat;
    txq.delete();
    issue_cmd(c);
    chk({tag, " cmplt_cleared"}, 32'(cmd_cmplt), 0);
    wait_cmplt(lat);
    chk_rng({tag, " cmplt_latency"}, lat, 20 * BAUD, 20 * BAUD + 4);
    chk({tag, " nbytes"}, 32'(txq.size()), 2);
    if (txq.size() == 2) begin
      chk({tag, " hi_byte"}, 32'(txq[0].data), 32'(eh));
      chk({tag, " lo_byte"}, 32'(txq[1].data), 32'(el));
      chk({tag, " stop_bits"}, 32'({txq[0].stop, txq[1].stop}), 3);
      chk_rng({tag, " byte_gap"}, txq[1].st - txq[0].st, 10 * BAUD, 10 * BAUD + 2);
    end
  endtask

  typedef struct {
    logic [15:0] c;
    logic [7:0]  eh;
    logic [7:0]  el;
  } cmd_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr_after;
    logic       exp_rdy;
    logic [7:0] exp_resp;
  } rx_vec_t;

  cmd_vec_t cv[4];
  rx_vec_t  rv[5];
  int       lat_rx;
  int       cnt;
  int       lat;
  logic [15:0] rc;
  logic [7:0]  rb;
  logic        rdy_exp;
  logic [7:0]  resp_exp;

  initial begin
    cv[0] = '{16'h4600, 8'h46, 8'h00};
    cv[1] = '{16'h0155, 8'h01, 8'h55};
    cv[2] = '{16'hFF80, 8'hFF, 8'h80};
    cv[3] = '{16'hA50F, 8'hA5, 8'h0F};
    rv[0] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A};
    rv[1] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'h81};   // bad stop bit still delivers
    rv[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    rv[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF};
    rv[4] = '{8'h96, 1'b1, 1'b1, 1'b0, 8'h96};

    rst_n = 1'b1; RX = 1'b1; cmd = '0; snd_cmd = 1'b0; clr_resp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    chk("reset TX", 32'(TX), 1);
    chk("reset cmd_cmplt", 32'(cmd_cmplt), 0);
    chk("reset rdy", 32'(rdy), 0);
    chk("reset resp", 32'(resp), 0);
    repeat (100) @(negedge clk);
    chk("idle TX", 32'(TX), 1);
    chk("idle cmd_cmplt", 32'(cmd_cmplt), 0);
    chk("idle rdy", 32'(rdy), 0);
    txq.delete();

    for (int i = 0; i < 4; i++) run_cmd($sformatf("cmd%0d", i), cv[i].c, cv[i].eh, cv[i].el);

    // Response ack, measuring the RX start-to-rdy latency for the collision test.
    cnt = 0;
    fork
      send_rx(POS_ACK, 1'b1);
      begin
        while (rdy !== 1'b1 && cnt < 2000) begin
          @(negedge clk);
          cnt++;
        end
      end
    join
    lat_rx = cnt;
    chk_rng("ack rx_latency", lat_rx, BAUD * 19 / 2, BAUD * 10);
    chk("ack rdy", 32'(rdy), 1);
    chk("ack resp", 32'(resp), 32'(POS_ACK));
    pulse_clr("ack", 1'b0);

    // Clear on the very cycle the next byte completes: set wins.
    fork
      send_rx(NEG_ACK, 1'b1);
      begin
        repeat (lat_rx - 1) @(negedge clk);
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
      end
    join
    chk("collide rdy", 32'(rdy), 1);
    chk("collide resp", 32'(resp), 32'(NEG_ACK));
    send_rx(8'h3C, 1'b1);
    chk("overwrite rdy", 32'(rdy), 1);
    chk("overwrite resp", 32'(resp), 'h3C);
    pulse_clr("overwrite", 1'b0);

    // Short low glitch on RX must not produce a byte.
    RX = 1'b0;
    repeat (20) @(negedge clk);
    RX = 1'b1;
    repeat (1200) @(negedge clk);
    chk("glitch rdy", 32'(rdy), 0);
    chk("glitch resp", 32'(resp), 'h3C);

    for (int i = 0; i < 5; i++) begin
      send_rx(rv[i].data, rv[i].stop);
      chk($sformatf("rxv%0d rdy", i), 32'(rdy), 1);
      chk($sformatf("rxv%0d resp", i), 32'(resp), 32'(rv[i].exp_resp));
      if (rv[i].clr_after) pulse_clr($sformatf("rxv%0d", i), 1'b0);
      chk($sformatf("rxv%0d rdy_final", i), 32'(rdy), 32'(rv[i].exp_rdy));
    end

    // snd_cmd while busy is ignored.
    txq.delete();
    issue_cmd(16'h1234);
    repeat (500) @(negedge clk);
    issue_cmd(16'hABCD);
    wait_cmplt(lat);
    chk("busy cmplt", 32'(cmd_cmplt), 1);
    repeat (1300) @(negedge clk);
    chk("busy nbytes", 32'(txq.size()), 2);
    if (txq.size() == 2) begin
      chk("busy hi_byte", 32'(txq[0].data), 'h12);
      chk("busy lo_byte", 32'(txq[1].data), 'h34);
    end
    chk("busy cmplt_held", 32'(cmd_cmplt), 1);

    // Accepted snd_cmd with a pending response.
    send_rx(8'h77, 1'b1);
    chk("macro rdy_before", 32'(rdy), 1);
    issue_cmd(16'h0102);
`ifdef CMD_MASTER_RDY_AUTOCLR_EN
    chk("macro rdy_after_snd", 32'(rdy), 0);
`else
    chk("macro rdy_after_snd", 32'(rdy), 1);
`endif
    wait_cmplt(lat);
    chk_rng("macro cmplt_latency", lat, 20 * BAUD, 20 * BAUD + 4);

    // Randomized full-duplex traffic against a flag/byte model.
    rdy_exp  = rdy;
    resp_exp = resp;
    for (int k = 0; k < 6; k++) begin
      rc = 16'($urandom);
      rb = 8'($urandom);
      fork
        run_cmd($sformatf("rnd%0d", k), rc, rc[15:8], rc[7:0]);
        begin
          repeat ($urandom_range(0, 300)) @(negedge clk);
          send_rx(rb, 1'b1);
        end
      join
      rdy_exp  = 1'b1;
      resp_exp = rb;
      chk($sformatf("rnd%0d rdy", k), 32'(rdy), 32'(rdy_exp));
      chk($sformatf("rnd%0d resp", k), 32'(resp), 32'(resp_exp));
      if ($urandom_range(0, 1) == 1) begin
        rdy_exp = 1'b0;
        pulse_clr($sformatf("rnd%0d", k), rdy_exp);
      end
    end

    // Reset mid-frame aborts everything.
    send_rx(8'h5A, 1'b1);
    issue_cmd(16'h00FF);
    repeat (300) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst TX", 32'(TX), 1);
    chk("midrst cmd_cmplt", 32'(cmd_cmplt), 0);
    chk("midrst rdy", 32'(rdy), 0);
    chk("midrst resp", 32'(resp), 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2500) @(negedge clk);
    chk("midrst TX_idle", 32'(TX), 1);
    chk("midrst no_cmplt", 32'(cmd_cmplt), 0);
    run_cmd("postrst", 16'hC3A5, 8'hC3, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
